// File: rtl/apb_timer.sv
// apb_timer: APB-mapped 32-bit down-counter with prescaler, auto-reload
// and a sticky expiry flag driving a level interrupt.
module apb_timer #(
    parameter int PRESCALE_W = 8
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [3:0]  PSTRB,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS
    } state_t;

    localparam logic [15:0] OFF_CTRL   = 16'h0000;
    localparam logic [15:0] OFF_LOAD   = 16'h0004;
    localparam logic [15:0] OFF_COUNT  = 16'h0008;
    localparam logic [15:0] OFF_STATUS = 16'h000C;

    state_t state;
    state_t state_nxt;

    logic                  en;
    logic                  auto_reload;
    logic                  irq_en;
    logic [PRESCALE_W-1:0] prescale;
    logic [31:0]           load;
    logic [31:0]           count;
    logic                  expired;
    logic [PRESCALE_W-1:0] presc;

    logic [15:0] off;
    logic        sel_ctrl;
    logic        sel_load;
    logic        sel_count;
    logic        sel_status;
    logic        err;
    logic        in_access;
    logic        commit;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_status;
    logic        rd_ok;
    logic        en_wr;
    logic        en_rise;
    logic        tick;
    logic        expire;
    logic        w1c;
    logic [31:0] load_wr;
    logic [31:0] ctrl_view;
    logic [31:0] rdata;
    logic        unused_addr_hi;

    // Upper address bits belong to the system decoder.
    assign off            = PADDR[15:0];
    assign unused_addr_hi = ^PADDR[31:16];

    assign sel_ctrl   = (off == OFF_CTRL);
    assign sel_load   = (off == OFF_LOAD);
    assign sel_count  = (off == OFF_COUNT);
    assign sel_status = (off == OFF_STATUS);

    assign err = (off[1:0] != 2'b00)
              || (off > OFF_STATUS)
              || (PWRITE && sel_count);

    assign in_access = (state == ACCESS);
    assign commit    = in_access && PSEL && PENABLE && !err;
    assign wr_ctrl   = commit && PWRITE && sel_ctrl;
    assign wr_load   = commit && PWRITE && sel_load;
    assign wr_status = commit && PWRITE && sel_status;
    assign rd_ok     = commit && !PWRITE;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (PSEL && PENABLE) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                state_nxt = PSEL ? ACCESS : IDLE;
            end
            ACCESS: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        load_wr = load;
        for (int i = 0; i < 4; i++) begin
            if (PSTRB[i]) begin
                load_wr[i*8 +: 8] = PWDATA[i*8 +: 8];
            end
        end
    end

    assign en_wr   = PSTRB[0] ? PWDATA[0] : en;
    assign en_rise = wr_ctrl && !en && en_wr;

    // A LOAD write in the same cycle swallows the tick.
    assign tick   = en && (presc == prescale);
    assign expire = tick && !wr_load && (count == 32'd0);
    assign w1c    = wr_status && PSTRB[0] && PWDATA[0];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            en          <= 1'b0;
            auto_reload <= 1'b0;
            irq_en      <= 1'b0;
            prescale    <= '0;
        end else begin
            if (wr_ctrl) begin
                en <= en_wr;
                if (PSTRB[0]) begin
                    auto_reload <= PWDATA[1];
                    irq_en      <= PWDATA[2];
                end
                if (PSTRB[1]) begin
                    prescale <= PWDATA[8 +: PRESCALE_W];
                end
            end
            if (expire && !auto_reload) begin
                en <= 1'b0;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            presc <= '0;
        end else if (wr_load || en_rise) begin
            presc <= '0;
        end else if (en) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            load  <= '0;
            count <= '0;
        end else begin
            if (wr_load) begin
                load  <= load_wr;
                count <= load_wr;
            end else if (tick) begin
                if (count != 32'd0) begin
                    count <= count - 1'b1;
                end else if (auto_reload) begin
                    count <= load;
                end
            end
        end
    end

    // Expiry wins over a simultaneous clear so no event is lost.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            expired <= 1'b0;
        end else if (expire) begin
            expired <= 1'b1;
        end else if (w1c) begin
            expired <= 1'b0;
        end
    end

    always_comb begin
        ctrl_view                    = '0;
        ctrl_view[0]                 = en;
        ctrl_view[1]                 = auto_reload;
        ctrl_view[2]                 = irq_en;
        ctrl_view[8 +: PRESCALE_W]   = prescale;
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            sel_ctrl:   rdata = ctrl_view;
            sel_load:   rdata = load;
            sel_count:  rdata = count;
            sel_status: rdata = {31'd0, expired};
            default:    rdata = '0;
        endcase
    end

    assign PRDATA  = rd_ok ? rdata : 32'd0;
    assign PREADY  = in_access;
    assign PSLVERR = in_access && err;
    assign IRQ     = expired && irq_en;

endmodule
